fft_control: RTL and testbench
==============================

FFT_CONTROL -- requirements
Module: fft_control

Interface
REQ-001 The block SHALL have parameter N_POINT, default 256, FFT length; fixed radix-4, four stages, four data banks of 64 words.
REQ-002 The block SHALL have parameter PIPE_LAT, default 6, cycles from read-address issue to write-address issue (butterfly and RAM latency).
REQ-003 The block SHALL have one clock, iCLK  in  1, with all state on the rising edge.
REQ-004 The block SHALL have iRESET  in  1, asynchronous active-low reset.
REQ-005 The block SHALL have iSTART  in  1, start request, sampled only while idle.
REQ-006 The block SHALL have oBANK_RD_ROT  out  2, read bank rotation r: butterfly input m is in bank (r+m) mod 4.
REQ-007 The block SHALL have oBANK_WR_ROT  out  2, write bank rotation: butterfly output m goes to bank (rot+m) mod 4.
REQ-008 The block SHALL have oADDR_RD_0..oADDR_RD_3  out  6 each, read address for banks 0..3.
REQ-009 The block SHALL have oADDR_WR  out  6, common write address for all four banks.
REQ-010 The block SHALL have oADDR_COEF  out  6, twiddle ROM address, base exponent for input 1.
REQ-011 The block SHALL have oBUT_TYPE  out  1, 1 = last stage with trivial twiddles.
REQ-012 The block SHALL have oRDY  out  1, 1 = idle/complete, 0 = busy.

Function
REQ-013 States SHALL be IDLE, RUN and DRAIN.
- IDLE: iSTART=1 goes to RUN with stage s=0, butterfly k=0.
- RUN: issues one butterfly per cycle, k=0..63; after k=63 goes to DRAIN.
- DRAIN: lasts PIPE_LAT cycles; then RUN with s+1, or IDLE after s=3.
REQ-014 iSTART SHALL be ignored outside IDLE; a start is accepted in the same cycle oRDY is high.
REQ-015 oRDY SHALL fall on the edge that samples iSTART=1 in IDLE, and rise on the edge after the last write address of stage 3 is presented.
REQ-016 With PIPE_LAT=6, the stage-s butterfly-k reads SHALL appear at cycle 1+70s+k after the start edge; oRDY SHALL be high again at cycle 281.
REQ-017 Indexing per butterfly SHALL be:
- Q = 64 >> 2s, G = 4Q, g = k div Q, j = k mod Q;
- input indices n_m = gG + j + mQ for m=0..3.
REQ-018 Bank and address mapping SHALL be:
- bank(n) = (sum of the base-4 digits of n) mod 4;
- word address = n[7:2];
- oBANK_RD_ROT = bank(n_0);
- oADDR_RD_b = address of the input m with (r+m) mod 4 = b.
REQ-019 oADDR_COEF SHALL equal j << 2s, and oBUT_TYPE SHALL equal 1 only when s=3.
REQ-020 oADDR_WR SHALL equal k and oBANK_WR_ROT SHALL equal oBANK_RD_ROT, both delayed by exactly PIPE_LAT cycles.
REQ-021 All outputs SHALL be registered; read/coef/type outputs SHALL hold their last value outside RUN, and write outputs SHALL hold outside their delayed window.

Reset
REQ-022 While iRESET=0, all address, rotation and type outputs SHALL be 0, oRDY SHALL be 1, the state SHALL be IDLE, and the delay pipeline SHALL be cleared.
REQ-023 Reset asserted mid-operation SHALL abort immediately; after release the block SHALL wait in IDLE for a new iSTART.

Verification
REQ-024 Stage 0, k=0 SHALL give rot 0; RD_0..3 = 0,16,32,48; COEF 0; TYPE 0.
REQ-025 Stage 0, k=5 SHALL give rot 2; RD_0..3 = 33,49,1,17; COEF 5; six cycles later WR=5 and WR_ROT=2.
REQ-026 Stage 1, k=17 SHALL give rot 2; RD_0..3 = 24,28,16,20; COEF 4; TYPE 0.
REQ-027 Stage 3, k=7 SHALL give rot 0; all RD = 7; COEF 0; TYPE 1.
REQ-028 A start pulse SHALL drop oRDY at the next edge and raise it 281 cycles after the start edge; a second iSTART while busy SHALL change nothing, and a new start after completion SHALL repeat the sequence identically.
REQ-029 Reset pulsed at stage 2 SHALL return all outputs to 0 and oRDY to 1, with no activity until the next iSTART.

Source files
------------

// File: rtl/fft_control.sv
// fft_control: address, bank-rotation and sequencing control for a 256-point in-place radix-4 FFT
// Ports: iCLK/iRESET (async active-low) clock and reset; iSTART starts a transform while idle;
//        oBANK_RD_ROT/oADDR_RD_0..3 bank rotation and per-bank read addresses of the current butterfly;
//        oADDR_COEF twiddle exponent for input 1; oBUT_TYPE marks the last (trivial-twiddle) stage;
//        oADDR_WR/oBANK_WR_ROT write address and rotation, PIPE_LAT cycles after the reads; oRDY idle flag.
module fft_control #(
  parameter int N_POINT  = 256,
  parameter int PIPE_LAT = 6
) (
  input  logic       iCLK,
  input  logic       iRESET,
  input  logic       iSTART,
  output logic [1:0] oBANK_RD_ROT,
  output logic [1:0] oBANK_WR_ROT,
  output logic [5:0] oADDR_RD_0,
  output logic [5:0] oADDR_RD_1,
  output logic [5:0] oADDR_RD_2,
  output logic [5:0] oADDR_RD_3,
  output logic [5:0] oADDR_WR,
  output logic [5:0] oADDR_COEF,
  output logic       oBUT_TYPE,
  output logic       oRDY
);
  localparam int NB = N_POINT / 4;
  localparam int DW = $clog2(PIPE_LAT) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t        state_q;
  logic [1:0]    s_q;
  logic [5:0]    k_q;
  logic [DW-1:0] d_q;
  logic          rdy_q;
  logic [1:0]    rd_rot_q, wr_rot_q;
  logic [5:0]    addr_rd_q [4];
  logic [5:0]    wr_addr_q, coef_q;
  logic          type_q;
  logic          pv_q [PIPE_LAT];
  logic [5:0]    pk_q [PIPE_LAT];
  logic [1:0]    pr_q [PIPE_LAT];
  logic [5:0]    mask;
  logic [2:0]    sh;
  logic [7:0]    n [4];
  logic [1:0]    rot_d;
  logic [5:0]    addr_rd_d [4];
  logic [5:0]    coef_d;
  // Digit-sum modulo 4 of a base-4 index; the 2-bit add wraps naturally.
  function automatic logic [1:0] bank(input logic [7:0] x);
    return x[1:0] + x[3:2] + x[5:4] + x[7:6];
  endfunction
  // mask selects j (k mod Q); the bits above it are g, which lands at g*4Q after a shift by 2.
  always_comb begin
    mask = 6'd63 >> {s_q, 1'b0};
    sh = 3'd6 - {s_q, 1'b0};
    for (int m = 0; m < 4; m++)
      n[m] = {k_q & ~mask, 2'b00} | (8'(m) << sh) | {2'b00, k_q & mask};
    rot_d = bank(n[0]);
    for (int b = 0; b < 4; b++)
      addr_rd_d[b] = n[2'(b) - rot_d][7:2];
    coef_d = (k_q & mask) << {s_q, 1'b0};
  end
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= IDLE;
      s_q <= '0;
      k_q <= '0;
      d_q <= '0;
      rdy_q <= 1'b1;
      rd_rot_q <= '0;
      wr_rot_q <= '0;
      wr_addr_q <= '0;
      coef_q <= '0;
      type_q <= 1'b0;
      for (int b = 0; b < 4; b++) addr_rd_q[b] <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pk_q[i] <= '0;
        pr_q[i] <= '0;
      end
    end else begin
      // rdy_q gates acceptance so a start is only taken while oRDY is already high.
      rdy_q <= (state_q == IDLE) && !(rdy_q && iSTART);
      if (state_q == IDLE && rdy_q && iSTART) begin
        state_q <= RUN;
        s_q <= '0;
        k_q <= '0;
      end else if (state_q == RUN) begin
        rd_rot_q <= rot_d;
        for (int b = 0; b < 4; b++) addr_rd_q[b] <= addr_rd_d[b];
        coef_q <= coef_d;
        type_q <= (s_q == 2'd3);
        k_q <= k_q + 6'd1;
        if (k_q == 6'(NB - 1)) begin
          state_q <= DRAIN;
          d_q <= '0;
        end
      end else if (state_q == DRAIN) begin
        d_q <= d_q + 1'b1;
        if (d_q == DW'(PIPE_LAT - 1)) begin
          state_q <= (s_q == 2'd3) ? IDLE : RUN;
          s_q <= s_q + 2'd1;
          k_q <= '0;
        end
      end
      // Delay line aligned with the read registers; the write registers load PIPE_LAT edges later.
      pv_q[0] <= (state_q == RUN);
      pk_q[0] <= k_q;
      pr_q[0] <= rot_d;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pk_q[i] <= pk_q[i-1];
        pr_q[i] <= pr_q[i-1];
      end
      if (pv_q[PIPE_LAT-1]) begin
        wr_addr_q <= pk_q[PIPE_LAT-1];
        wr_rot_q <= pr_q[PIPE_LAT-1];
      end
    end
  end
  assign oBANK_RD_ROT = rd_rot_q;
  assign oBANK_WR_ROT = wr_rot_q;
  assign oADDR_RD_0 = addr_rd_q[0];
  assign oADDR_RD_1 = addr_rd_q[1];
  assign oADDR_RD_2 = addr_rd_q[2];
  assign oADDR_RD_3 = addr_rd_q[3];
  assign oADDR_WR = wr_addr_q;
  assign oADDR_COEF = coef_q;
  assign oBUT_TYPE = type_q;
  assign oRDY = rdy_q;
endmodule

// File: tb/tb_fft_control.sv
// tb_fft_control: directed self-checking bench for fft_control
module tb_fft_control;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] rd_rot, wr_rot;
  logic [5:0] rd0, rd1, rd2, rd3, wr, coef;
  logic       typ, rdy;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  fft_control #(.N_POINT(256), .PIPE_LAT(6)) dut (
    .iCLK(clk),
    .iRESET(rst_n),
    .iSTART(start),
    .oBANK_RD_ROT(rd_rot),
    .oBANK_WR_ROT(wr_rot),
    .oADDR_RD_0(rd0),
    .oADDR_RD_1(rd1),
    .oADDR_RD_2(rd2),
    .oADDR_RD_3(rd3),
    .oADDR_WR(wr),
    .oADDR_COEF(coef),
    .oBUT_TYPE(typ),
    .oRDY(rdy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic go_to(input int t);
    while (cyc < t) tick();
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic chk_rd(input string tag, input int r, input int a0, input int a1,
                        input int a2, input int a3, input int c, input int t);
    chk({tag, "_rot"}, 32'(rd_rot), 32'(r));
    chk({tag, "_rd0"}, 32'(rd0), 32'(a0));
    chk({tag, "_rd1"}, 32'(rd1), 32'(a1));
    chk({tag, "_rd2"}, 32'(rd2), 32'(a2));
    chk({tag, "_rd3"}, 32'(rd3), 32'(a3));
    chk({tag, "_coef"}, 32'(coef), 32'(c));
    chk({tag, "_type"}, 32'(typ), 32'(t));
  endtask
  task automatic chk_idle(input string tag);
    chk_rd(tag, 0, 0, 0, 0, 0, 0, 0);
    chk({tag, "_wr"}, 32'(wr), 0);
    chk({tag, "_wrrot"}, 32'(wr_rot), 0);
    chk({tag, "_rdy"}, 32'(rdy), 1);
  endtask
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
  endtask
  initial begin
    #12;
    chk_idle("reset");
    rst_n = 1'b1;
    tick();
    tick();
    chk_idle("idle");
    // run 1
    do_start();
    chk("rdy_fall", 32'(rdy), 0);
    go_to(1);
    chk_rd("s0k0", 0, 0, 16, 32, 48, 0, 0);
    go_to(6);
    chk_rd("s0k5", 2, 33, 49, 1, 17, 5, 0);
    go_to(12);
    chk("s0k5_wr", 32'(wr), 5);
    chk("s0k5_wrrot", 32'(wr_rot), 2);
    go_to(30);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_rdy", 32'(rdy), 0);
    go_to(88);
    chk_rd("s1k17", 2, 24, 28, 16, 20, 4, 0);
    go_to(151);
    chk_rd("s2k10", 0, 8, 9, 10, 11, 32, 0);
    go_to(218);
    chk_rd("s3k7", 0, 7, 7, 7, 7, 0, 1);
    go_to(280);
    chk("rdy_280", 32'(rdy), 0);
    chk("last_wr", 32'(wr), 63);
    chk("last_wrrot", 32'(wr_rot), 1);
    go_to(281);
    chk("rdy_281", 32'(rdy), 1);
    chk_rd("hold", 1, 63, 63, 63, 63, 0, 1);
    go_to(290);
    chk("rdy_hold", 32'(rdy), 1);
    chk("wr_hold", 32'(wr), 63);
    chk_rd("hold2", 1, 63, 63, 63, 63, 0, 1);
    // run 2 must repeat identically
    do_start();
    chk("r2_rdy_fall", 32'(rdy), 0);
    go_to(6);
    chk_rd("r2_s0k5", 2, 33, 49, 1, 17, 5, 0);
    go_to(12);
    chk("r2_wr", 32'(wr), 5);
    chk("r2_wrrot", 32'(wr_rot), 2);
    go_to(88);
    chk_rd("r2_s1k17", 2, 24, 28, 16, 20, 4, 0);
    go_to(280);
    chk("r2_rdy_280", 32'(rdy), 0);
    go_to(281);
    chk("r2_rdy_281", 32'(rdy), 1);
    // run 3 aborted by reset in stage 2
    do_start();
    go_to(151);
    chk_rd("r3_s2k10", 0, 8, 9, 10, 11, 32, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("abort");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk_idle("post_abort");
    // start after abort works again
    do_start();
    go_to(6);
    chk_rd("r4_s0k5", 2, 33, 49, 1, 17, 5, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
